// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding, the ARM bubble word,
// and ARM instruction field positions reused by every stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    localparam logic [31:0] ARM_NOP = 32'hE1A00000;

    localparam int COND_HI   = 31;
    localparam int COND_LO   = 28;
    localparam int RN_HI     = 19;
    localparam int RN_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 12;
    localparam int RM_HI     = 3;
    localparam int RM_LO     = 0;
    localparam int SHIFT_HI  = 11;
    localparam int SHIFT_LO  = 0;
    localparam int OFFSET_HI = 23;
    localparam int OFFSET_LO = 0;

endpackage

// File: rtl/ifid_field_decode.sv
// Combinational split of a 32-bit ARM instruction word into its register,
// condition, shifter-operand and branch-offset fields.
module ifid_field_decode
    import pipe_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [3:0]  o_cond,
    output logic [3:0]  o_rn,
    output logic [3:0]  o_rd,
    output logic [3:0]  o_rm,
    output logic [11:0] o_shift,
    output logic [23:0] o_offset
);

    assign o_cond   = i_word[COND_HI:COND_LO];
    assign o_rn     = i_word[RN_HI:RN_LO];
    assign o_rd     = i_word[RD_HI:RD_LO];
    assign o_rm     = i_word[RM_HI:RM_LO];
    assign o_shift  = i_word[SHIFT_HI:SHIFT_LO];
    assign o_offset = i_word[OFFSET_HI:OFFSET_LO];

endmodule

// File: rtl/ifid_stage_reg.sv
// IF/ID stage register: two-entry skid buffer with registered in_ready,
// synchronous flush, NOP substitution when empty and a saturating stall counter.
module ifid_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   INSTR_W   = 32,
    parameter int                   PC_W      = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(ARM_NOP),
    parameter int                   CNT_W     = 16
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4,
    output logic [3:0]         out_cond,
    output logic [3:0]         out_rn,
    output logic [3:0]         out_rd,
    output logic [3:0]         out_rm,
    output logic [11:0]        out_shift,
    output logic [23:0]        out_offset,
    output logic [CNT_W-1:0]   stall_cnt
);

    skid_state_t        r_state;
    logic               r_in_ready;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_pc4;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc4;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_in_xfer;
    logic w_out_xfer;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = r_in_ready;
    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Flush wins over everything; an output transfer in that cycle has already happened.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state      <= EMPTY;
            r_in_ready   <= 1'b1;
            r_main_instr <= NOP_INSTR;
            r_main_pc4   <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc4   <= '0;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_instr <= in_instr;
                        r_main_pc4   <= in_pc4;
                        r_state      <= FULL;
                    end
                end
                FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_instr <= in_instr;
                        r_main_pc4   <= in_pc4;
                    end else if (w_in_xfer) begin
                        r_skid_instr <= in_instr;
                        r_skid_pc4   <= in_pc4;
                        r_state      <= SKID;
                        r_in_ready   <= 1'b0;
                    end else if (w_out_xfer) begin
                        r_state <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_out_xfer) begin
                        r_main_instr <= r_skid_instr;
                        r_main_pc4   <= r_skid_pc4;
                        r_state      <= FULL;
                        r_in_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign out_instr = out_valid ? r_main_instr : NOP_INSTR;
    assign out_pc4   = out_valid ? r_main_pc4 : '0;

    ifid_field_decode u_decode (
        .i_word   (out_instr[31:0]),
        .o_cond   (out_cond),
        .o_rn     (out_rn),
        .o_rd     (out_rd),
        .o_rm     (out_rm),
        .o_shift  (out_shift),
        .o_offset (out_offset)
    );

endmodule
